// File: rtl/skin_decider_pkg.sv
// rtl/skin_decider_pkg.sv - shared pixel width and chroma/background thresholds
package skin_decider_pkg;

  localparam int PIX_W    = 8;
  localparam int BG_DEPTH = 4;

  localparam logic [PIX_W-1:0] CB_MIN    = 8'd77;
  localparam logic [PIX_W-1:0] CB_MAX    = 8'd127;
  localparam logic [PIX_W-1:0] CR_MIN    = 8'd133;
  localparam logic [PIX_W-1:0] CR_MAX    = 8'd173;
  localparam logic [PIX_W-1:0] BG_THRESH = 8'd20;

  function automatic logic in_window(input logic [PIX_W-1:0] v,
                                     input logic [PIX_W-1:0] lo,
                                     input logic [PIX_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/skin_bg_model.sv
// rtl/skin_bg_model.sv - learned background luma ring, averager and abs-diff compare
module skin_bg_model
  import skin_decider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             learn,
  input  logic [PIX_W-1:0] luma,
  output logic             far
);

  logic [PIX_W-1:0]        bg [BG_DEPTH];
  logic [1:0]              ptr;
  logic [PIX_W+1:0]        sum;
  logic [PIX_W-1:0]        avg;
  logic signed [PIX_W:0]   delta;
  logic signed [PIX_W:0]   neg_delta;
  logic [PIX_W-1:0]        mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BG_DEPTH; i++) bg[i] <= '0;
      ptr <= '0;
    end else if (learn) begin
      bg[ptr] <= luma;
      ptr     <= ptr + 2'd1;
    end
  end

  // Compare uses the ring as it stood before this edge; average is truncated.
  always_comb begin
    sum       = {2'b00, bg[0]} + {2'b00, bg[1]} + {2'b00, bg[2]} + {2'b00, bg[3]};
    avg       = sum[PIX_W+1:2];
    delta     = $signed({1'b0, luma}) - $signed({1'b0, avg});
    neg_delta = -delta;
    mag       = delta[PIX_W] ? neg_delta[PIX_W-1:0] : delta[PIX_W-1:0];
    far       = (mag >= BG_THRESH);
  end

endmodule

// File: rtl/skin_decider.sv
// rtl/skin_decider.sv - per-pixel chroma skin classifier with optional background gating
module skin_decider
  import skin_decider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] luma_ch,
  input  logic [PIX_W-1:0] cb_ch,
  input  logic [PIX_W-1:0] cr_ch,
  input  logic             BACKGROUND_DIFFERENCE,
  output logic             object_image
);

  logic skin;
  logic far;

  assign skin = in_window(cb_ch, CB_MIN, CB_MAX) && in_window(cr_ch, CR_MIN, CR_MAX);

  skin_bg_model u_bg (
    .clk   (clk),
    .rst   (rst),
    .learn (!BACKGROUND_DIFFERENCE),
    .luma  (luma_ch),
    .far   (far)
  );

  always_ff @(posedge clk) begin
    if (rst) object_image <= 1'b0;
    else     object_image <= skin && (!BACKGROUND_DIFFERENCE || far);
  end

endmodule

// File: tb/tb_skin_decider.sv
// tb/tb_skin_decider.sv - scoreboard bench for skin_decider against a behavioural model
module tb_skin_decider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] luma_ch = '0;
  logic [7:0] cb_ch = '0;
  logic [7:0] cr_ch = '0;
  logic       bd = 1'b0;
  logic       object_image;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  string name_q[$];

  int m_bg[4];
  int m_ptr;

  skin_decider dut (
    .clk                   (clk),
    .rst                   (rst),
    .luma_ch               (luma_ch),
    .cb_ch                 (cb_ch),
    .cr_ch                 (cr_ch),
    .BACKGROUND_DIFFERENCE (bd),
    .object_image          (object_image)
  );

  always #5 clk = ~clk;

  // Reference: skin from the chroma rules, background as mean of the last four learned lumas.
  function automatic bit model_step(input bit r, input int y, input int cb, input int cr, input bit d);
    bit is_skin;
    int avg, diff;
    is_skin = (cb >= 77 && cb <= 127) && (cr >= 133 && cr <= 173);
    if (r) begin
      foreach (m_bg[i]) m_bg[i] = 0;
      m_ptr = 0;
      return 0;
    end
    if (!d) begin
      m_bg[m_ptr] = y;
      m_ptr = (m_ptr + 1) % 4;
      return is_skin;
    end
    avg  = (m_bg[0] + m_bg[1] + m_bg[2] + m_bg[3]) / 4;
    diff = (y > avg) ? y - avg : avg - y;
    return is_skin && (diff >= 20);
  endfunction

  task automatic apply(input string nm, input bit r, input int y, input int cb, input int cr, input bit d);
    @(negedge clk);
    rst = r; luma_ch = 8'(y); cb_ch = 8'(cb); cr_ch = 8'(cr); bd = d;
    exp_q.push_back(model_step(r, y, cb, cr, d));
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      bit    e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (object_image !== e) begin
        n_fail++;
        $display("FAIL %s: object_image=%0b expected %0b", nm, object_image, e);
      end
    end
  end

  initial begin
    m_ptr = 0;
    foreach (m_bg[i]) m_bg[i] = 0;

    apply("reset", 1, 55, 100, 150, 1);
    apply("bd_skin", 0, 100, 100, 150, 1);
    apply("bd_cb_out", 0, 123, 145, 190, 1);

    apply("win_lo", 0, 50, 77, 133, 0);
    apply("win_hi", 0, 50, 127, 173, 0);
    apply("cb_below", 0, 50, 76, 150, 0);
    apply("cr_above", 0, 50, 100, 174, 0);

    for (int i = 0; i < 4; i++) apply("learn100", 0, 100, 100, 150, 0);
    apply("diff10", 0, 110, 100, 150, 1);
    apply("diff20", 0, 120, 100, 150, 1);
    apply("diff25_below", 0, 75, 100, 150, 1);

    apply("mid_reset", 1, 100, 100, 150, 0);
    apply("bg_cleared", 0, 15, 100, 150, 1);

    apply("wrap10", 0, 10, 100, 150, 0);
    apply("wrap20", 0, 20, 100, 150, 0);
    apply("wrap30", 0, 30, 100, 150, 0);
    apply("wrap40", 0, 40, 100, 150, 0);
    apply("wrap200", 0, 200, 100, 150, 0);
    apply("avg72_eq", 0, 72, 100, 150, 1);
    apply("avg72_p20", 0, 92, 100, 150, 1);

    for (int i = 0; i < 400; i++)
      apply("random", ($urandom_range(0, 49) == 0), $urandom_range(0, 255),
            $urandom_range(60, 140), $urandom_range(120, 190), $urandom_range(0, 1));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d outputs pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
